// File: rtl/icache_ctrl_multiline_if.sv
// Bus bundle between the multi-line icache controller and its environment
// (fetch-stage UFP, tag/data datapath, DFP arbiter).
// Optional perf-counter signals exist only when ICACHE_PERF_CNT_EN is defined.
interface icache_ctrl_multiline_if #(
    parameter int MAX_LINES = 2,
    parameter int IDX_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1,
    parameter int NL_W      = $clog2(MAX_LINES + 1)
`ifdef ICACHE_PERF_CNT_EN
    , parameter int CNT_W   = 32
`endif
);
    // UFP side
    logic             cache_read_request;
    logic [NL_W-1:0]  req_lines;
    logic             ready;
    logic             ufp_resp;

    // datapath side
    logic             cache_hit;
    logic             sram_array_csb0;
    logic             write_from_mem;
    logic             save_sram_dout;
    logic [IDX_W-1:0] line_idx;

    // DFP side
    logic             dfp_read;
    logic             dfp_write;
    logic             dfp_resp;

`ifdef ICACHE_PERF_CNT_EN
    logic             perf_clr;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;
`endif

    // Controller view: serves requests and drives the datapath/DFP controls.
    modport slave (
        input  cache_read_request, req_lines, cache_hit, dfp_resp,
`ifdef ICACHE_PERF_CNT_EN
        input  perf_clr,
        output hit_count, miss_count,
`endif
        output dfp_read, dfp_write, sram_array_csb0, write_from_mem,
               save_sram_dout, line_idx, ready, ufp_resp
    );

    // Environment view: issues requests and reports hit/DFP status.
    modport master (
        output cache_read_request, req_lines, cache_hit, dfp_resp,
`ifdef ICACHE_PERF_CNT_EN
        output perf_clr,
        input  hit_count, miss_count,
`endif
        input  dfp_read, dfp_write, sram_array_csb0, write_from_mem,
               save_sram_dout, line_idx, ready, ufp_resp
    );
endinterface

// File: rtl/icache_ctrl_multiline.sv
// Instruction-cache controller for fetches spanning 1..MAX_LINES consecutive
// cachelines. Each line is checked in turn through a single-port SRAM; a miss
// fills that line from the DFP, re-reads it, and resumes checking.
// Optional hit/miss perf counters: define ICACHE_PERF_CNT_EN.
module icache_ctrl_multiline #(
    parameter int MAX_LINES = 2,
    parameter int IDX_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1,
    parameter int NL_W      = $clog2(MAX_LINES + 1)
`ifdef ICACHE_PERF_CNT_EN
    , parameter int CNT_W   = 32
`endif
) (
    input logic                     clk,
    input logic                     rst,
    icache_ctrl_multiline_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FETCH,
        FETCH_WAIT
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] line_idx, line_idx_n;
    logic [NL_W-1:0]  nlines, nlines_n;
    logic             last_line;
    logic             accept;

    // A zero span still fetches one line; oversize spans saturate at MAX_LINES.
    function automatic logic [NL_W-1:0] clamp_lines(input logic [NL_W-1:0] n);
        if (n == '0)
            return NL_W'(1);
        else if (n > NL_W'(MAX_LINES))
            return NL_W'(MAX_LINES);
        else
            return n;
    endfunction

    assign last_line    = (NL_W'(line_idx) == (nlines - NL_W'(1)));
    assign bus.line_idx = line_idx;

    // State, line index and latched span registers.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            line_idx <= '0;
            nlines   <= NL_W'(1);
        end else begin
            state    <= state_n;
            line_idx <= line_idx_n;
            nlines   <= nlines_n;
        end
    end

    // Next-state and output decode; accept is shared by IDLE and the final CHECK.
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_n             = state;
        line_idx_n          = line_idx;
        nlines_n            = nlines;
        accept              = 1'b0;
        bus.dfp_read        = 1'b0;
        bus.dfp_write       = 1'b0;
        bus.sram_array_csb0 = 1'b1;
        bus.write_from_mem  = 1'b0;
        bus.save_sram_dout  = 1'b0;
        bus.ready           = 1'b0;
        bus.ufp_resp        = 1'b0;

        unique case (state)
            IDLE: begin
                bus.ready = 1'b1;
                accept    = bus.cache_read_request;
            end

            CHECK: begin
                if (bus.cache_hit) begin
                    bus.save_sram_dout = 1'b1;
                    if (last_line) begin
                        bus.ufp_resp = 1'b1;
                        bus.ready    = 1'b1;
                        accept       = bus.cache_read_request;
                        if (!bus.cache_read_request) begin
                            line_idx_n = '0;
                            state_n    = IDLE;
                        end
                    end else begin
                        bus.sram_array_csb0 = 1'b0;
                        line_idx_n          = line_idx + IDX_W'(1);
                    end
                end else begin
                    state_n = FETCH;
                end
            end

            FETCH: begin
                bus.dfp_read = 1'b1;
                if (bus.dfp_resp) begin
                    bus.write_from_mem  = 1'b1;
                    bus.sram_array_csb0 = 1'b0;
                    state_n             = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                bus.sram_array_csb0 = 1'b0;
                state_n             = CHECK;
            end

            default: state_n = IDLE;
        endcase

        if (accept) begin
            bus.sram_array_csb0 = 1'b0;
            line_idx_n          = '0;
            nlines_n            = clamp_lines(bus.req_lines);
            state_n             = CHECK;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic             recheck;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // Saturating hit/miss counters; the CHECK right after a fill is not a hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recheck  <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            recheck <= (state == FETCH_WAIT);
            if (bus.perf_clr) begin
                hit_cnt  <= '0;
                miss_cnt <= '0;
            end else if (state == CHECK) begin
                if (bus.cache_hit && !recheck && (hit_cnt != '1))
                    hit_cnt <= hit_cnt + CNT_W'(1);
                if (!bus.cache_hit && (miss_cnt != '1))
                    miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl_multiline.sv
// Directed self-checking bench for icache_ctrl_multiline with MAX_LINES=4.
// Perf-counter checks are compiled in when ICACHE_PERF_CNT_EN is defined.
module tb_icache_ctrl_multiline;

    localparam int MAX_LINES = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    icache_ctrl_multiline_if #(.MAX_LINES(MAX_LINES)) bus ();

    icache_ctrl_multiline #(.MAX_LINES(MAX_LINES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every control output for the current cycle.
    task automatic expect_outs(input string tag, input int rdy, input int ufp, input int dread,
                               input int csb, input int save, input int wfm, input int idx);
        check({tag, ".ready"},    32'(bus.ready),           32'(rdy));
        check({tag, ".ufp_resp"}, 32'(bus.ufp_resp),        32'(ufp));
        check({tag, ".dfp_read"}, 32'(bus.dfp_read),        32'(dread));
        check({tag, ".csb0"},     32'(bus.sram_array_csb0), 32'(csb));
        check({tag, ".save"},     32'(bus.save_sram_dout),  32'(save));
        check({tag, ".wr_mem"},   32'(bus.write_from_mem),  32'(wfm));
        check({tag, ".line_idx"}, 32'(bus.line_idx),        32'(idx));
        check({tag, ".dfp_wr"},   32'(bus.dfp_write),       32'd0);
    endtask

    task automatic drive(input logic req, input int lines, input logic hit, input logic resp);
        bus.cache_read_request = req;
        bus.req_lines          = 3'(lines);
        bus.cache_hit          = hit;
        bus.dfp_resp           = resp;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled 3 time units after the rising edge.
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
`ifdef ICACHE_PERF_CNT_EN
        bus.perf_clr = 1'b0;
`endif
        #3;
        expect_outs("reset", 1, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        // 1-line request that hits: ufp_resp one cycle after accept.
        drive(1'b1, 1, 1'b0, 1'b0); settle();
        expect_outs("t1.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 1, 1'b1, 1'b0); settle();
        expect_outs("t1.check", 1, 1, 0, 1, 1, 0, 0);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        expect_outs("t1.idle", 1, 0, 0, 1, 0, 0, 0);
        tick();

        // 3-line all-hit request; next request held high through busy cycles.
        drive(1'b1, 3, 1'b0, 1'b0); settle();
        expect_outs("t2.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b1, 1, 1'b1, 1'b0); settle();
        expect_outs("t2.chk0", 0, 0, 0, 0, 1, 0, 0);
        tick(); settle();
        expect_outs("t2.chk1", 0, 0, 0, 0, 1, 0, 1);
        tick(); settle();
        expect_outs("t2.chk2", 1, 1, 0, 0, 1, 0, 2);
        tick();
        drive(1'b0, 1, 1'b1, 1'b0); settle();
        expect_outs("t2.b2b", 1, 1, 0, 1, 1, 0, 0);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        expect_outs("t2.idle", 1, 0, 0, 1, 0, 0, 0);
        tick();

        // 2-line request: line 1 misses, DFP answers on the 5th FETCH cycle.
        drive(1'b1, 2, 1'b0, 1'b0); settle();
        expect_outs("t3.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 2, 1'b1, 1'b0); settle();
        expect_outs("t3.chk0", 0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1'b0, 2, 1'b0, 1'b0); settle();
        expect_outs("t3.miss", 0, 0, 0, 1, 0, 0, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            expect_outs($sformatf("t3.fetch%0d", i), 0, 0, 1, 1, 0, 0, 1);
            tick();
        end
        drive(1'b0, 2, 1'b0, 1'b1); settle();
        expect_outs("t3.resp", 0, 0, 1, 0, 0, 1, 1);
        tick();
        // dfp_resp left high in FETCH_WAIT must be ignored.
        settle();
        expect_outs("t3.fwait", 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(1'b0, 2, 1'b1, 1'b0); settle();
        expect_outs("t3.recheck", 1, 1, 0, 1, 1, 0, 1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        expect_outs("t3.idle", 1, 0, 0, 1, 0, 0, 0);
        tick();

        // req_lines=0 is served as a single line.
        drive(1'b1, 0, 1'b0, 1'b0); settle();
        expect_outs("t4a.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0); settle();
        expect_outs("t4a.check", 1, 1, 0, 1, 1, 0, 0);
        tick();

        // req_lines=7 is clamped to 4 lines.
        drive(1'b1, 7, 1'b0, 1'b0); settle();
        expect_outs("t4b.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_outs($sformatf("t4b.chk%0d", i), 0, 0, 0, 0, 1, 0, i);
            tick();
        end
        settle();
        expect_outs("t4b.chk3", 1, 1, 0, 1, 1, 0, 3);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        expect_outs("t4b.idle", 1, 0, 0, 1, 0, 0, 0);
        tick();

        // Asynchronous reset in the middle of a fill for line 1.
        drive(1'b1, 2, 1'b0, 1'b0); settle();
        expect_outs("t5.accept", 1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1'b0, 2, 1'b1, 1'b0);
        tick();
        drive(1'b0, 2, 1'b0, 1'b0);
        tick(); settle();
        expect_outs("t5.fetch", 0, 0, 1, 1, 0, 0, 1);
        rst = 1'b1;
        #1;
        expect_outs("t5.rst", 1, 0, 0, 1, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        expect_outs("t5.after", 1, 0, 0, 1, 0, 0, 0);
        tick();

`ifdef ICACHE_PERF_CNT_EN
        check("perf.rst_hit",  bus.hit_count,  32'd0);
        check("perf.rst_miss", bus.miss_count, 32'd0);
        // One single-line hit, then a 3-line request whose line 1 misses.
        drive(1'b1, 1, 1'b0, 1'b0); tick();
        drive(1'b0, 1, 1'b1, 1'b0); tick();
        drive(1'b1, 3, 1'b0, 1'b0); tick();
        drive(1'b0, 3, 1'b1, 1'b0); tick();
        drive(1'b0, 3, 1'b0, 1'b0); tick();
        drive(1'b0, 3, 1'b0, 1'b1); tick();
        drive(1'b0, 3, 1'b0, 1'b0); tick();
        drive(1'b0, 3, 1'b1, 1'b0); tick();
        settle();
        check("perf.last_ufp", 32'(bus.ufp_resp), 32'd1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0); settle();
        check("perf.hit",  bus.hit_count,  32'd3);
        check("perf.miss", bus.miss_count, 32'd1);
        bus.perf_clr = 1'b1;
        tick();
        bus.perf_clr = 1'b0;
        settle();
        check("perf.clr_hit",  bus.hit_count,  32'd0);
        check("perf.clr_miss", bus.miss_count, 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
